// File: rtl/ps2_scan_queue.sv
`default_nettype none
// ============================================================================
// ps2_scan_queue : PS/2 byte parser (break strip, E0 tagging, repeat filter)
//                  feeding a show-ahead key-event FIFO.
// Revision 1.0
// ============================================================================
module ps2_scan_queue #(
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int REPEAT_FILTER = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_key_pressed,
  input  logic [7:0]        ps2_key_data,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [31:0]       rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   C_FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);
  localparam logic [7:0]        C_BYTE_EXT = 8'hE0;
  localparam logic [7:0]        C_BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          last_make_q, last_make_d;
  logic                held_q, held_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [8:0]          mem_q [DEPTH];

  logic                w_cand_v;
  logic [8:0]          w_cand;
  logic                w_brk_v;
  logic [8:0]          w_brk_key;
  logic                w_drop;
  logic                w_push;
  logic                w_pop;
  logic                w_wr;
  logic                w_empty;
  logic                w_full;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == C_FULL_CNT);

  // Parser: decode one byte per strobe into a candidate make or a break.
  always_comb begin
    state_d   = state_q;
    w_cand_v  = 1'b0;
    w_cand    = 9'd0;
    w_brk_v   = 1'b0;
    w_brk_key = 9'd0;
    if (ps2_key_pressed) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_key_data == C_BYTE_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_key_data == C_BYTE_BRK) begin
            state_d = ST_BRK;
          end else if ((ps2_key_data != 8'h00) && (ps2_key_data != 8'hFF)) begin
            w_cand_v = 1'b1;
            w_cand   = {1'b0, ps2_key_data};
          end
        end
        ST_EXT: begin
          if (ps2_key_data == C_BYTE_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (ps2_key_data != C_BYTE_EXT) begin
            w_cand_v = 1'b1;
            w_cand   = {1'b1, ps2_key_data};
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_brk_v   = 1'b1;
          w_brk_key = {1'b0, ps2_key_data};
          state_d   = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_brk_v   = 1'b1;
          w_brk_key = {1'b1, ps2_key_data};
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Repeat filter and held-key tracking; last_make follows accepted makes
  // even when the FIFO ends up discarding them.
  always_comb begin
    w_drop      = (REPEAT_FILTER != 0) && held_q && (w_cand == last_make_q);
    w_push      = w_cand_v && !w_drop;
    last_make_d = last_make_q;
    held_d      = held_q;
    if (w_push) begin
      last_make_d = w_cand;
      held_d      = 1'b1;
    end else if (w_brk_v && (w_brk_key == last_make_q)) begin
      held_d = 1'b0;
    end
  end

  // FIFO bookkeeping: a pop on the same edge frees the slot for a push.
  always_comb begin
    w_pop      = rd_en && !w_empty;
    w_wr       = w_push && (!w_full || w_pop);
    wr_ptr_d   = w_wr  ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = w_pop ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
    count_d    = count_q + {{ADDR_W{1'b0}}, w_wr} - {{ADDR_W{1'b0}}, w_pop};
    overflow_d = overflow_q;
    if (w_push && w_full && !w_pop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      last_make_q <= 9'd0;
      held_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_make_q <= last_make_d;
      held_q      <= held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked by empty.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= w_cand;
    end
  end

  assign rd_data  = w_empty ? 32'h0 : {23'b0, mem_q[rd_ptr_q]};
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_queue.sv
`default_nettype none
// tb_ps2_scan_queue : directed plus random stimulus against a queue-based
// reference model; filtered (rf1) and unfiltered (rf0) instances in parallel.
module tb_ps2_scan_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic        clock;
  logic        reset;
  logic        ps2_key_pressed;
  logic [7:0]  ps2_key_data;
  logic        rd_en;
  logic        clr_overflow;

  logic [31:0]     rd_data1, rd_data0;
  logic            empty1, empty0, full1, full0, ovf1, ovf0;
  logic [ADDR_W:0] count1, count0;

  int n_total = 0;
  int n_bad   = 0;

  ps2_scan_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REPEAT_FILTER(1)) u_dut_rf1 (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .rd_en(rd_en), .clr_overflow(clr_overflow),
    .rd_data(rd_data1), .empty(empty1), .full(full1), .count(count1),
    .overflow(ovf1)
  );

  ps2_scan_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REPEAT_FILTER(0)) u_dut_rf0 (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .rd_en(rd_en), .clr_overflow(clr_overflow),
    .rd_data(rd_data0), .empty(empty0), .full(full0), .count(count0),
    .overflow(ovf0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: index 0 = filtered instance, 1 = unfiltered instance.
  logic [8:0] q_m [2][$];
  bit         ext_p [2];
  bit         brk_p [2];
  bit         held  [2];
  bit         ovf   [2];
  logic [8:0] last  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_head(input int i);
    if (q_m[i].size() == 0) return 32'h0;
    return {23'b0, q_m[i][0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q_m[i].delete();
      ext_p[i] = 0; brk_p[i] = 0; held[i] = 0; ovf[i] = 0; last[i] = 9'd0;
    end
  endtask

  task automatic model_step(input bit ps, input logic [7:0] b, input bit rd, input bit clr);
    int         s;
    bit         pop, push, set;
    logic [8:0] cand;
    for (int i = 0; i < 2; i++) begin
      s = q_m[i].size();
      pop = rd && (s > 0);
      push = 0; set = 0; cand = 9'd0;
      if (ps) begin
        if (brk_p[i]) begin
          if ({ext_p[i], b} == last[i]) held[i] = 0;
          brk_p[i] = 0; ext_p[i] = 0;
        end else if (b == 8'hE0) begin
          ext_p[i] = 1;
        end else if (b == 8'hF0) begin
          brk_p[i] = 1;
        end else if (!ext_p[i] && (b == 8'h00 || b == 8'hFF)) begin
          // receiver error byte outside a prefix: ignored
        end else begin
          cand = {ext_p[i], b};
          ext_p[i] = 0;
          if (!(i == 0 && held[i] && cand == last[i])) begin
            last[i] = cand; held[i] = 1; push = 1;
          end
        end
      end
      if (pop) void'(q_m[i].pop_front());
      if (push) begin
        if (s < DEPTH || pop) q_m[i].push_back(cand);
        else set = 1;
      end
      if (set) ovf[i] = 1;
      else if (clr) ovf[i] = 0;
    end
  endtask

  task automatic check_all();
    chk("rf1.rd_data",  rd_data1, m_head(0));
    chk("rf1.count",    32'(count1), 32'(q_m[0].size()));
    chk("rf1.empty",    32'(empty1), 32'(q_m[0].size() == 0));
    chk("rf1.full",     32'(full1),  32'(q_m[0].size() == DEPTH));
    chk("rf1.overflow", 32'(ovf1),   32'(ovf[0]));
    chk("rf0.rd_data",  rd_data0, m_head(1));
    chk("rf0.count",    32'(count0), 32'(q_m[1].size()));
    chk("rf0.empty",    32'(empty0), 32'(q_m[1].size() == 0));
    chk("rf0.full",     32'(full0),  32'(q_m[1].size() == DEPTH));
    chk("rf0.overflow", 32'(ovf0),   32'(ovf[1]));
  endtask

  task automatic cyc(input bit ps, input logic [7:0] b, input bit rd, input bit clr);
    @(negedge clock);
    check_all();
    ps2_key_pressed = ps;
    ps2_key_data    = b;
    rd_en           = rd;
    clr_overflow    = clr;
    model_step(ps, b, rd, clr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic key(input logic [7:0] b);
    cyc(1, b, 0, 0);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    ps2_key_pressed = 0; ps2_key_data = 8'h00; rd_en = 0; clr_overflow = 0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; ps2_key_pressed = 0; ps2_key_data = 8'h00; rd_en = 0; clr_overflow = 0;
    model_reset();
    #2;
    do_reset();

    // Plain key with break sequence
    key(8'h1C); key(8'hF0); key(8'h1C);
    chk("plain.rd", rd_data1, 32'h0000001C);
    chk("plain.count", 32'(count1), 32'd1);
    cyc(0, 8'h00, 1, 0); idle(1);
    chk("plain.empty", 32'(empty1), 32'd1);
    chk("plain.rd0", rd_data1, 32'h0);

    // Extended key, then reset in the middle of a prefix
    do_reset();
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    chk("ext.rd", rd_data1, 32'h00000175);
    chk("ext.count", 32'(count1), 32'd1);
    do_reset();
    cyc(1, 8'hE0, 0, 0);
    do_reset();
    key(8'h75);
    chk("ext_rst.rd", rd_data1, 32'h00000075);

    // Repeat filter
    do_reset();
    key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C); key(8'h1C);
    chk("rpt.count_rf1", 32'(count1), 32'd2);
    chk("rpt.count_rf0", 32'(count0), 32'd4);

    // Fill and overflow, then full push+pop, then drain
    do_reset();
    for (int k = 1; k <= 17; k++) cyc(1, 8'(k), 0, 0);
    idle(1);
    chk("fill.full", 32'(full1), 32'd1);
    chk("fill.count", 32'(count1), 32'd16);
    chk("fill.ovf", 32'(ovf1), 32'd1);
    chk("fill.head", rd_data1, 32'h00000001);
    cyc(0, 8'h00, 0, 1); idle(1);
    chk("clr.ovf", 32'(ovf1), 32'd0);
    cyc(1, 8'h22, 1, 0); idle(1);
    chk("fpp.count", 32'(count1), 32'd16);
    chk("fpp.ovf", 32'(ovf1), 32'd0);
    chk("fpp.head", rd_data1, 32'h00000002);
    for (int k = 0; k < 16; k++) cyc(0, 8'h00, 1, 0);
    idle(1);

    // Pointer wrap with push/pop pairs, then reads on empty
    do_reset();
    for (int k = 0; k < 40; k++) begin
      cyc(1, 8'(8'h20 + k), 0, 0);
      cyc(0, 8'h00, 1, 0);
    end
    for (int k = 0; k < 3; k++) cyc(0, 8'h00, 1, 0);
    idle(1);
    chk("wrap.count", 32'(count1), 32'd0);
    chk("wrap.rd", rd_data1, 32'h0);

    // Randomized traffic with phases biased toward filling and draining
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] b;
      int         sel;
      int         rd_pct;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hF0;
        3: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(1, 6));
      endcase
      rd_pct = ((k / 250) % 2 == 0) ? 10 : 60;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < 50, b, $urandom_range(0, 99) < rd_pct,
            $urandom_range(0, 15) == 0);
      end
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_queue.md
Name: ps2_scan_queue

Overview:
- Keyboard input stage directly upstream of the processor.
- Takes raw PS/2 bytes from the PS/2 receiver as one-cycle strobes.
- Strips break (release) sequences, tags extended keys and optionally suppresses typematic repeats.
- Queues the resulting key-press events in a FIFO. The processor pops the FIFO through its memory-mapped keyboard read path.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2.
- ADDR_W, 4: log2(DEPTH).
- REPEAT_FILTER, 1: when 1, a repeated make code with no intervening break is dropped.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. 0 clears all state immediately.
- ps2_key_pressed  in  1  one-cycle strobe: ps2_key_data is valid this cycle.
- ps2_key_data  in  8  received PS/2 byte.
- rd_en  in  1  pop request from the processor.
- clr_overflow  in  1  clears the sticky overflow flag.
- rd_data  out  32  head entry = {23'b0, ext, code[7:0]}; 32'h0 when empty.
- empty  out  1  FIFO has no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  ADDR_W+1  current number of entries.
- overflow  out  1  sticky: a push was lost because the FIFO was full.

Behaviour:
- Reset (reset=0, async): FIFO cleared; count=0, empty=1, full=0, overflow=0; parser state=IDLE; last_make=0, held=0. rd_data=0 during reset.
- Parser FSM, evaluated only on cycles with ps2_key_pressed=1:
  - IDLE, byte E0 → EXT.
  - IDLE, byte F0 → BRK.
  - IDLE, byte 00 or FF (receiver error) → dropped, stay IDLE.
  - IDLE, any other byte → candidate push {ext=0, byte}, stay IDLE.
  - EXT, byte F0 → EXT_BRK.
  - EXT, byte E0 → stay EXT.
  - EXT, any other byte → candidate push {ext=1, byte}, → IDLE.
  - BRK, any byte → no push, → IDLE. If {0,byte}=={last_make}, clear held.
  - EXT_BRK, any byte → no push, → IDLE. If {1,byte}=={last_make}, clear held.
- Repeat filter:
  - Applies when REPEAT_FILTER=1 and the candidate {ext,code} equals last_make with held=1: candidate dropped, no FIFO write.
  - Otherwise last_make←candidate, held←1, and the candidate is pushed.
- Push timing: the entry is written on the rising edge that samples the strobe. empty, count and full reflect the write from the next cycle.
- Read path:
  - Show-ahead: rd_data is combinational from the head entry.
  - rd_en=1 with empty=0 pops on that rising edge; rd_data shows the next entry in the following cycle.
  - rd_en with empty=1 is ignored; rd_data stays 0 and count never underflows.
- Simultaneous push and pop:
  - Both occur in the same edge; count is unchanged.
  - This holds when full=1: the pop frees a slot, the push succeeds and overflow is not set.
  - With empty=1 and a simultaneous push, the pop is ignored and the push lands (count=1).
- Push while full with no pop: entry discarded, overflow←1, FIFO contents unchanged. Parser state and last_make still update.
- Overflow clear: clr_overflow=1 clears overflow on the next edge. If a set and a clear occur on the same edge, set wins.
- Pointers: read and write pointers are ADDR_W bits and wrap modulo DEPTH. full = (count==DEPTH).
- Mid-operation reset: an asynchronous assertion discards in-flight prefix state, e.g. reset after E0 returns the FSM to IDLE.
- The strobe always precedes any FIFO side-effect: no combinational path from ps2_key_* to rd_data.

Test Plan:
- Plain key: strobe bytes 1C, F0, 1C (one per 4 cycles) → exactly one entry; rd_data=32'h0000001C, count=1. After rd_en pulse: empty=1, rd_data=0.
- Extended key: E0,75,E0,F0,75 → one entry rd_data=32'h00000175. E0 then reset=0 for 1 cycle then 75 → entry 32'h00000075.
- Repeat filter: 1C,1C,1C,F0,1C,1C → two entries (1C, 1C). With REPEAT_FILTER=0 → four entries.
- Fill/overflow: 17 distinct make codes 01..11 (skipping none) with DEPTH=16 → full=1, count=16, overflow=1. Head=01 and the 17th code is lost. clr_overflow → overflow=0.
- Full push+pop: with full=1, strobe 22 and rd_en in the same cycle → count stays 16, overflow stays 0. Draining yields 02..10 then 22.
- Underflow/wrap: 40 push/pop pairs cycling the pointers past DEPTH twice → data order preserved. rd_en on empty leaves count=0 and rd_data=0.
